double_threshold_hyst: RTL and testbench

DOUBLE_THRESHOLD_HYST -- requirements
Module: double_threshold_hyst

---
 rtl/double_threshold_hyst.sv | 117 +++++++++++
 tb/tb_double_threshold_hyst.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/double_threshold_hyst.sv
// double_threshold_hyst: streaming Canny double-threshold with single-pass 8-neighbour hysteresis.
// Emits one 8'hFF/8'h00 edge pixel per accepted input, lagging by one row plus one pixel.
module double_threshold_hyst #(
    parameter int WIDTH      = 634,
    parameter int DEPTH      = 506,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  data_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] thr_low,
    input  logic [DATA_WIDTH-1:0] thr_high,
    output logic                  start_sync,
    output logic                  edge_en,
    output logic [7:0]            edge_data,
    output logic                  frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(DEPTH);
    localparam logic [1:0] NONE = 2'b00, WEAK = 2'b01, STRONG = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] lo, hi;
    logic [CW-1:0] in_col, out_col;
    logic [RW-1:0] in_row, out_row;
    logic [1:0] lb1 [WIDTH];
    logic [1:0] lb2 [WIDTH];
    logic [1:0] a0, b0, a1, b1, a2, b2;
    logic [1:0] t1, t2, cls;
    logic accept, step, primed, emit, last_in, last_out, border, strong_nb, edge_val;

    always_comb begin
        accept    = state == RUN && start && data_en;
        step      = accept || (state == FLUSH && start);
        primed    = in_row > RW'(1) || (in_row == RW'(1) && in_col != '0);
        emit      = (accept && primed) || (state == FLUSH && start);
        last_in   = in_row == RW'(DEPTH - 1) && in_col == CW'(WIDTH - 1);
        last_out  = out_row == RW'(DEPTH - 1) && out_col == CW'(WIDTH - 1);
        cls       = state == FLUSH ? NONE : in_data >= hi ? STRONG : in_data >= lo ? WEAK : NONE;
        t1        = lb1[in_col];
        t2        = lb2[in_col];
        // Window: a=col-2, b=col-1, new column {t2,t1,cls}; centre is b1.
        strong_nb = a0 == STRONG || b0 == STRONG || t2 == STRONG || a1 == STRONG ||
                    t1 == STRONG || a2 == STRONG || b2 == STRONG || cls == STRONG;
        border    = out_row == '0 || out_row == RW'(DEPTH - 1) ||
                    out_col == '0 || out_col == CW'(WIDTH - 1);
        edge_val  = !border && (b1 == STRONG || (b1 == WEAK && strong_nb));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = !start ? IDLE : (accept && last_in) ? FLUSH : RUN;
            FLUSH:   state_nx = !start ? IDLE : last_out ? DONE : FLUSH;
            DONE:    state_nx = start ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lo         <= '0;
            hi         <= '0;
            in_col     <= '0;
            in_row     <= '0;
            out_col    <= '0;
            out_row    <= '0;
            edge_en    <= 1'b0;
            edge_data  <= 8'h00;
            frame_done <= 1'b0;
            start_sync <= 1'b0;
        end else begin
            state      <= state_nx;
            start_sync <= state == RUN || state == FLUSH;
            edge_en    <= emit;
            edge_data  <= (emit && edge_val) ? 8'hFF : 8'h00;
            frame_done <= emit && last_out;
            if (state == IDLE && start) begin
                lo      <= thr_low;
                hi      <= thr_high;
                in_col  <= '0;
                in_row  <= '0;
                out_col <= '0;
                out_row <= '0;
            end else begin
                if (step) begin
                    in_col <= in_col == CW'(WIDTH - 1) ? '0 : in_col + 1'b1;
                    in_row <= in_col == CW'(WIDTH - 1) ? in_row + 1'b1 : in_row;
                end
                if (emit) begin
                    out_col <= out_col == CW'(WIDTH - 1) ? '0 : out_col + 1'b1;
                    out_row <= out_col == CW'(WIDTH - 1) ? out_row + 1'b1 : out_row;
                end
            end
        end
    end

    // Class history needs no reset: stale entries only ever reach border outputs.
    always_ff @(posedge clk) begin
        if (step) begin
            lb1[in_col] <= cls;
            lb2[in_col] <= t1;
            a0 <= b0;
            b0 <= t2;
            a1 <= b1;
            b1 <= t1;
            a2 <= b2;
            b2 <= cls;
        end
    end
endmodule

// File: tb/tb_double_threshold_hyst.sv
// tb_double_threshold_hyst: directed frames on an 8x6 image checked against a 2-D reference.
module tb_double_threshold_hyst;
    localparam int W = 8, D = 6, N = W * D, DW = 16;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, data_en = 1'b0;
    logic [DW-1:0] in_data = '0, thr_low = '0, thr_high = '0;
    logic start_sync, edge_en, frame_done;
    logic [7:0] edge_data;

    int n_checks = 0, n_fail = 0;
    int pix [N];
    logic [7:0] expd [N];
    logic [7:0] out_d [64];
    time out_t [64];
    int nout = 0, fd_idx = -1, fd_count = 0;
    time t_acc9 = 0;

    double_threshold_hyst #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .data_en(data_en), .in_data(in_data),
        .thr_low(thr_low), .thr_high(thr_high), .start_sync(start_sync),
        .edge_en(edge_en), .edge_data(edge_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (edge_en === 1'b1) begin
            if (nout < 64) begin
                out_d[nout] = edge_data;
                out_t[nout] = $time;
            end
            if (frame_done === 1'b1) begin
                fd_idx = nout;
                fd_count++;
            end
            nout++;
        end
    end

    function automatic void model(input int lo, input int hi);
        for (int r = 0; r < D; r++)
            for (int c = 0; c < W; c++) begin
                bit s, wk, nb;
                s  = pix[r*W+c] >= hi;
                wk = !s && pix[r*W+c] >= lo;
                nb = 0;
                if (r == 0 || r == D - 1 || c == 0 || c == W - 1) begin
                    expd[r*W+c] = 8'h00;
                end else begin
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            if ((dr != 0 || dc != 0) && pix[(r+dr)*W+c+dc] >= hi) nb = 1;
                    expd[r*W+c] = (s || (wk && nb)) ? 8'hFF : 8'h00;
                end
            end
    endfunction

    task automatic fill(input int v, input int idx, input int vspec);
        for (int i = 0; i < N; i++) pix[i] = v;
        if (idx >= 0) pix[idx] = vspec;
    endtask

    task automatic clear_mon();
        nout = 0;
        fd_idx = -1;
        fd_count = 0;
    endtask

    task automatic begin_frame(input int lo, input int hi);
        clear_mon();
        thr_low = DW'(lo);
        thr_high = DW'(hi);
        start = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drive(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            data_en = 1'b1;
            in_data = DW'(pix[i]);
            @(posedge clk);
            if (i == 9) t_acc9 = $time;
            #1;
            data_en = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic finish_frame(input string name);
        int k;
        for (k = 0; k < 40 && fd_count == 0; k++) @(posedge clk);
        #1;
        check({name, "_done_timeout"}, k < 40, 1);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string name);
        check({name, "_count"}, nout, N);
        check({name, "_fd_idx"}, fd_idx, N - 1);
        check({name, "_fd_count"}, fd_count, 1);
        for (int j = 0; j < N; j++) check($sformatf("%s_pix%0d", name, j), out_d[j], expd[j]);
    endtask

    task automatic full_frame(input string name, input int lo, input int hi, input int gap);
        model(lo, hi);
        begin_frame(lo, hi);
        drive(N, gap);
        finish_frame(name);
        check_frame(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_edge_en", edge_en, 0);
        check("rst_edge_data", edge_data, 0);
        check("rst_start_sync", start_sync, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill(120, -1, 0);
        model(50, 100);
        begin_frame(50, 100);
        drive(N, 0);
        check("a_start_sync", start_sync, 1);
        finish_frame("a");
        check_frame("a");
        check("a_corner", out_d[0], 8'h00);
        check("a_interior", out_d[9], 8'hFF);

        fill(70, 19, 150);
        model(50, 100);
        begin_frame(50, 100);
        thr_low = '0;
        thr_high = '0;
        drive(N, 0);
        finish_frame("b");
        check_frame("b");
        check("b_window_tl", out_d[10], 8'hFF);
        check("b_window_br", out_d[28], 8'hFF);
        check("b_outside", out_d[29], 8'h00);

        fill(70, -1, 0);
        full_frame("c", 50, 100, 0);
        check("c_latency", out_t[0] - t_acc9, 5);

        fill(70, 19, 150);
        full_frame("d", 200, 100, 0);
        check("d_only_strong", out_d[19], 8'hFF);
        check("d_no_weak", out_d[18], 8'h00);

        fill(120, -1, 0);
        full_frame("e", 50, 100, 2);
        check("e_flush_first", out_t[39] - out_t[38], 10);
        check("e_flush_span", out_t[N-1] - out_t[39], 80);
        check("e_gap", out_t[10] - out_t[9], 30);

        fill(120, -1, 0);
        begin_frame(50, 100);
        drive(20, 0);
        start = 1'b0;
        @(posedge clk); #1;
        check("f_abort_count", nout, 11);
        check("f_abort_en", edge_en, 0);
        data_en = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        data_en = 1'b0;
        check("f_abort_quiet", nout, 11);
        check("f_abort_no_done", fd_count, 0);
        full_frame("f", 50, 100, 0);

        begin_frame(50, 100);
        drive(30, 0);
        rst = 1'b1;
        #1;
        check("g_rst_edge_en", edge_en, 0);
        check("g_rst_edge_data", edge_data, 0);
        check("g_rst_start_sync", start_sync, 0);
        check("g_rst_frame_done", frame_done, 0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        full_frame("g", 50, 100, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
